// File: rtl/wb_alu_sequencer.sv
// Wishbone front end that queues ALU commands, issues them one at a time over a
// start/done handshake, and buffers the 64-bit results for the host to drain.
module wb_alu_sequencer #(
  parameter logic [31:0] BASE_ADDRESS = 32'h3000_0000,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [31:0] i_wb_addr,
  input  logic [31:0] i_wb_data,
  output logic        o_wb_ack,
  output logic        o_wb_stall,
  output logic [31:0] o_wb_data,
  output logic        alu_start,
  output logic [3:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic        alu_done,
  input  logic [63:0] alu_result,
  output logic        irq
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_STORE} state_t;
  state_t state_q, state_d;

  // Address decode: six word-aligned registers starting at BASE_ADDRESS
  logic [31:0] offset;
  logic        access, mapped, wr_en, rd_en;
  logic [2:0]  sel;
  assign offset = i_wb_addr - BASE_ADDRESS;
  assign access = i_wb_cyc & i_wb_stb;
  assign mapped = (offset < 32'd24) && (offset[1:0] == 2'b00);
  assign sel    = offset[4:2];
  assign wr_en  = access & mapped & i_wb_we;
  assign rd_en  = access & mapped & ~i_wb_we;

  logic [31:0] a_stg_q, b_stg_q;
  logic        err_q, ovf_q;
  logic        ack_q;
  logic [31:0] rdata_q, rdata_d;
  logic [3:0]  alu_op_q;
  logic [31:0] alu_a_q, alu_b_q;
  logic [63:0] result_q;
  logic [TW-1:0] wait_cnt_q;
  logic        busy_c, alu_start_c;

  logic [67:0]   cmd_mem [DEPTH];
  logic [PW-1:0] cmd_wr_q, cmd_rd_q;
  logic [CW-1:0] cmd_cnt_q;
  logic [63:0]   res_mem [DEPTH];
  logic [PW-1:0] res_wr_q, res_rd_q;
  logic [CW-1:0] res_cnt_q;
  logic [63:0]   res_head;

  logic cmd_push_req, cmd_push, cmd_pop, ovf_set;
  logic res_push, res_pop, res_empty, timeout_hit;

  assign res_empty    = (res_cnt_q == '0);
  assign res_head     = res_mem[res_rd_q];
  assign cmd_pop      = (state_q == S_IDLE) && (cmd_cnt_q != '0);
  assign cmd_push_req = wr_en && (sel == 3'd2);
  // A full FIFO still accepts a push when the same cycle pops it
  assign cmd_push     = cmd_push_req && ((cmd_cnt_q != FULL_CNT) || cmd_pop);
  assign ovf_set      = cmd_push_req && !cmd_push;
  assign res_pop      = rd_en && (sel == 3'd5) && !res_empty;
  assign res_push     = (state_q == S_STORE) && ((res_cnt_q != FULL_CNT) || res_pop);
  assign timeout_hit  = (state_q == S_WAIT) && !alu_done && (wait_cnt_q == T_LAST);

  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cmd_cnt_q != '0) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (alu_done || timeout_hit) state_d = S_STORE;
      S_STORE: if (res_push) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    alu_start_c = 1'b0;
    busy_c      = 1'b1;
    case (state_q)
      S_IDLE:  busy_c = 1'b0;
      S_ISSUE: alu_start_c = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    rdata_d = '0;
    if (rd_en) begin
      case (sel)
        3'd3:    rdata_d = {17'b0, err_q, ovf_q, 4'(res_cnt_q), 4'b0, 4'(cmd_cnt_q), busy_c};
        3'd4:    rdata_d = res_empty ? 32'h0 : res_head[31:0];
        3'd5:    rdata_d = res_empty ? 32'h0 : res_head[63:32];
        default: rdata_d = '0;
      endcase
    end
  end

  // FIFO storage carries no reset; the counts alone define validity
  always_ff @(posedge clk) begin
    if (cmd_push) cmd_mem[cmd_wr_q] <= {i_wb_data[3:0], a_stg_q, b_stg_q};
    if (res_push) res_mem[res_wr_q] <= result_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      a_stg_q    <= '0;
      b_stg_q    <= '0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
      ack_q      <= 1'b0;
      rdata_q    <= '0;
      alu_op_q   <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      result_q   <= '0;
      wait_cnt_q <= '0;
      cmd_wr_q   <= '0;
      cmd_rd_q   <= '0;
      cmd_cnt_q  <= '0;
      res_wr_q   <= '0;
      res_rd_q   <= '0;
      res_cnt_q  <= '0;
    end else begin
      ack_q   <= access & mapped;
      rdata_q <= rdata_d;
      if (wr_en && sel == 3'd0) a_stg_q <= i_wb_data;
      if (wr_en && sel == 3'd1) b_stg_q <= i_wb_data;

      // Sticky flags: a new event in the same cycle as its clear wins
      if (timeout_hit)                                err_q <= 1'b1;
      else if (wr_en && sel == 3'd3 && i_wb_data[13]) err_q <= 1'b0;
      if (ovf_set)                                    ovf_q <= 1'b1;
      else if (wr_en && sel == 3'd3 && i_wb_data[12]) ovf_q <= 1'b0;

      if (cmd_pop) {alu_op_q, alu_a_q, alu_b_q} <= cmd_mem[cmd_rd_q];
      if (state_q == S_ISSUE)     wait_cnt_q <= '0;
      else if (state_q == S_WAIT) wait_cnt_q <= wait_cnt_q + TW'(1);
      if (state_q == S_WAIT && alu_done) result_q <= alu_result;
      else if (timeout_hit)              result_q <= '0;

      if (cmd_push) cmd_wr_q <= cmd_wr_q + PW'(1);
      if (cmd_pop)  cmd_rd_q <= cmd_rd_q + PW'(1);
      case ({cmd_push, cmd_pop})
        2'b10:   cmd_cnt_q <= cmd_cnt_q + CW'(1);
        2'b01:   cmd_cnt_q <= cmd_cnt_q - CW'(1);
        default: ;
      endcase

      if (res_push) res_wr_q <= res_wr_q + PW'(1);
      if (res_pop)  res_rd_q <= res_rd_q + PW'(1);
      case ({res_push, res_pop})
        2'b10:   res_cnt_q <= res_cnt_q + CW'(1);
        2'b01:   res_cnt_q <= res_cnt_q - CW'(1);
        default: ;
      endcase
    end
  end

  assign o_wb_ack   = ack_q;
  assign o_wb_stall = 1'b0;
  assign o_wb_data  = rdata_q;
  assign alu_start  = alu_start_c;
  assign alu_op     = alu_op_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign irq        = !res_empty || err_q;

endmodule

// File: tb/tb_wb_alu_sequencer.sv
// Randomized bench for wb_alu_sequencer: a behavioural ALU answers issues, and an
// ordered queue of expected results is checked as the host drains the result FIFO.
module tb_wb_alu_sequencer;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int DEPTH = 4;
  localparam int TIMEOUT = 255;
  localparam logic [31:0] OFF_A = 0, OFF_B = 4, OFF_CMD = 8, OFF_ST = 12, OFF_LO = 16, OFF_HI = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_wb_cyc = 1'b0, i_wb_stb = 1'b0, i_wb_we = 1'b0;
  logic [31:0] i_wb_addr = '0, i_wb_data = '0;
  logic        o_wb_ack, o_wb_stall;
  logic [31:0] o_wb_data;
  logic        alu_start;
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b;
  logic        alu_done;
  logic [63:0] alu_result;
  logic        irq;

  int checks = 0;
  int errors = 0;

  // Environment controls for the behavioural ALU
  int alu_lat = 1;
  bit alu_silent = 1'b0;
  int pulse_req = 0;
  int pulse_seen = 0;
  logic [3:0]  op_c;
  logic [31:0] a_c, b_c;

  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  wb_alu_sequencer #(.BASE_ADDRESS(BASE), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
    .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
    .o_wb_ack(o_wb_ack), .o_wb_stall(o_wb_stall), .o_wb_data(o_wb_data),
    .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_done(alu_done), .alu_result(alu_result), .irq(irq)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd2:    return 64'(a) * 64'(b);
      4'd3:    return {a, b};
      4'd4:    return {a ^ b, ~a};
      default: return 64'(a) + 64'(b);
    endcase
  endfunction

  function automatic logic [31:0] st(input bit busy, input int cmd, input int res, input bit ovf, input bit err);
    return 32'(busy) | (32'(cmd) << 1) | (32'(res) << 9) | (32'(ovf) << 13) | (32'(err) << 14);
  endfunction

  task automatic wb_write(input logic [31:0] off, input logic [31:0] d);
    @(negedge clk);
    i_wb_cyc = 1; i_wb_stb = 1; i_wb_we = 1; i_wb_addr = BASE + off; i_wb_data = d;
    @(negedge clk);
    i_wb_cyc = 0; i_wb_stb = 0; i_wb_we = 0;
    check_eq($sformatf("wr_ack@%0d", off), o_wb_ack, 1);
  endtask

  task automatic wb_read(input logic [31:0] off, input bit exp_ack, output logic [31:0] d);
    @(negedge clk);
    i_wb_cyc = 1; i_wb_stb = 1; i_wb_we = 0; i_wb_addr = BASE + off;
    @(negedge clk);
    i_wb_cyc = 0; i_wb_stb = 0;
    d = o_wb_data;
    check_eq($sformatf("rd_ack@%0d", off), o_wb_ack, exp_ack);
  endtask

  task automatic push_cmd(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input bit accept);
    wb_write(OFF_A, a);
    wb_write(OFF_B, b);
    wb_write(OFF_CMD, {28'b0, op});
    if (accept) exp_q.push_back(alu_fn(op, a, b));
  endtask

  task automatic drain_one();
    logic [31:0] s, lo, hi;
    logic [63:0] e;
    int n;
    n = 0;
    wb_read(OFF_ST, 1, s);
    while (s[12:9] == 0 && n < 1500) begin
      wb_read(OFF_ST, 1, s);
      n++;
    end
    check_eq("drain_wait", s[12:9] != 0, 1);
    wb_read(OFF_LO, 1, lo);
    wb_read(OFF_HI, 1, hi);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hX;
    check_eq("result", {hi, lo}, e);
  endtask

  // Behavioural ALU: answers each issue after alu_lat cycles unless silenced
  initial begin
    alu_done = 1'b0;
    alu_result = '0;
    forever begin
      @(negedge clk);
      if (pulse_req != pulse_seen) begin
        pulse_seen = pulse_req;
        alu_done = 1'b1;
        alu_result = 64'hDEAD_BEEF_0BAD_F00D;
        @(negedge clk);
        alu_done = 1'b0;
      end else if (alu_start === 1'b1 && !alu_silent) begin
        op_c = alu_op; a_c = alu_a; b_c = alu_b;
        repeat (alu_lat) @(negedge clk);
        alu_done = 1'b1;
        alu_result = alu_fn(op_c, a_c, b_c);
        @(negedge clk);
        alu_done = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] s, d;
    int occ, n, k;
    bit ovf_exp;

    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("rst_ack", o_wb_ack, 0);
    check_eq("rst_data", o_wb_data, 0);
    check_eq("rst_start", alu_start, 0);
    check_eq("rst_alu_regs", {alu_op, alu_a, alu_b}, 0);
    check_eq("rst_irq", irq, 0);
    wb_read(OFF_ST, 1, s);
    check_eq("rst_status", s, 0);

    // Test 1: single command, issue latency and result readback
    alu_lat = 3;
    wb_write(OFF_A, 5);
    wb_write(OFF_B, 7);
    @(negedge clk);
    i_wb_cyc = 1; i_wb_stb = 1; i_wb_we = 1; i_wb_addr = BASE + OFF_CMD; i_wb_data = 5;
    @(negedge clk);
    i_wb_cyc = 0; i_wb_stb = 0; i_wb_we = 0;
    check_eq("cmd_ack", o_wb_ack, 1);
    check_eq("start_n1", alu_start, 0);
    @(negedge clk);
    check_eq("start_n2", alu_start, 1);
    check_eq("issue_ops", {alu_op, alu_a, alu_b}, {4'd5, 32'd5, 32'd7});
    @(negedge clk);
    check_eq("start_n3", alu_start, 0);
    check_eq("held_ops", {alu_op, alu_a, alu_b}, {4'd5, 32'd5, 32'd7});
    exp_q.push_back(64'd12);
    repeat (8) @(negedge clk);
    wb_read(OFF_ST, 1, s);
    check_eq("t1_status", s, st(0, 0, 1, 0, 0));
    check_eq("t1_irq", irq, 1);
    wb_read(OFF_LO, 1, d);
    check_eq("t1_lo", d, 12);
    wb_read(OFF_HI, 1, d);
    check_eq("t1_hi", d, 0);
    void'(exp_q.pop_front());
    wb_read(OFF_ST, 1, s);
    check_eq("t1_status_after", s, st(0, 0, 0, 0, 0));

    // Test 2: overflow with the ALU busy on a long operation
    alu_lat = 100;
    push_cmd(4'($urandom), $urandom, $urandom, 1);
    repeat (4) @(negedge clk);
    occ = 0;
    ovf_exp = 0;
    for (int i = 0; i <= DEPTH; i++) begin
      push_cmd(4'($urandom), $urandom, $urandom, occ < DEPTH);
      if (occ < DEPTH) occ++;
      else ovf_exp = 1;
    end
    wb_read(OFF_ST, 1, s);
    check_eq("t2_status_ovf", s, st(1, occ, 0, ovf_exp, 0));
    wb_write(OFF_ST, 32'h1000);
    wb_read(OFF_ST, 1, s);
    check_eq("t2_status_w1c", s, st(1, occ, 0, 0, 0));
    while (exp_q.size() > 0) drain_one();
    wb_read(OFF_ST, 1, s);
    check_eq("t2_status_end", s, 0);

    // Test 3: result FIFO full backpressures the FSM in STORE
    alu_lat = 1;
    for (int i = 0; i < DEPTH + 1; i++) push_cmd(4'($urandom), $urandom, $urandom, 1);
    n = 0;
    wb_read(OFF_ST, 1, s);
    while (s != st(1, 0, DEPTH, 0, 0) && n < 200) begin
      wb_read(OFF_ST, 1, s);
      n++;
    end
    check_eq("t3_store_hold", s, st(1, 0, DEPTH, 0, 0));
    wb_read(OFF_HI, 1, d);
    check_eq("t3_hi_pop", d, exp_q[0][63:32]);
    void'(exp_q.pop_front());
    wb_read(OFF_ST, 1, s);
    check_eq("t3_status_refill", s, st(0, 0, DEPTH, 0, 0));
    while (exp_q.size() > 0) drain_one();

    // Test 4: ALU never answers, command times out
    alu_silent = 1;
    push_cmd(4'($urandom), $urandom, $urandom, 0);
    exp_q.push_back(64'h0);
    n = 0;
    wb_read(OFF_ST, 1, s);
    while (s[0] && n < 600) begin
      wb_read(OFF_ST, 1, s);
      n++;
    end
    check_eq("t4_status_err", s, st(0, 0, 1, 0, 1));
    check_eq("t4_irq", irq, 1);
    wb_write(OFF_ST, 32'h2000);
    wb_read(OFF_ST, 1, s);
    check_eq("t4_err_cleared", s, st(0, 0, 1, 0, 0));
    check_eq("t4_irq_res", irq, 1);
    drain_one();
    check_eq("t4_irq_end", irq, 0);

    // Test 5: reset during WAIT, late done ignored
    push_cmd(4'($urandom), $urandom, $urandom, 0);
    repeat (10) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check_eq("t5_rst_regs", {alu_start, irq, alu_op, alu_a, alu_b}, 0);
    pulse_req++;
    repeat (6) @(negedge clk);
    wb_read(OFF_ST, 1, s);
    check_eq("t5_status", s, 0);
    check_eq("t5_irq", irq, 0);
    alu_silent = 0;

    // Test 6: empty result read, write-only read, unmapped address
    wb_read(OFF_HI, 1, d);
    check_eq("t6_empty_hi", d, 0);
    wb_read(OFF_A, 1, d);
    check_eq("t6_wo_read", d, 0);
    wb_read(32'd24, 0, d);
    check_eq("t6_unmapped_data", d, 0);

    // Randomized batches
    for (int b = 0; b < 8; b++) begin
      k = $urandom_range(1, DEPTH);
      alu_lat = $urandom_range(1, 6);
      for (int i = 0; i < k; i++) push_cmd(4'($urandom_range(0, 5)), $urandom, $urandom, 1);
      while (exp_q.size() > 0) drain_one();
    end
    wb_read(OFF_ST, 1, s);
    check_eq("final_status", s, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
